// File: rtl/gsim_pkg.sv
// -----------------------------------------------------------------------------
// gsim_pkg
// Shared definitions for the Gauss-Seidel feeder: the shift-register command
// codes understood by the downstream vector shift register, the feeder FSM
// state encoding and a counter-width helper.
// -----------------------------------------------------------------------------
package gsim_pkg;

   // Shift-register commands. Only SH0 (hold) and SH1 (insert one word) are
   // ever issued by the feeder; the others are listed so the encoding stays
   // in one place for every block that talks to the shift register.
   typedef enum logic [2:0] {
      SH0 = 3'b000,
      SH1 = 3'b001,
      SH4 = 3'b010,
      SH5 = 3'b011,
      SH2 = 3'b100
   } sh_cmd_e;

   // Feeder FSM states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      RUN    = 2'd2,
      FINISH = 2'd3
   } state_e;

   // Width of an index counter over 'depth' elements (never below one bit).
   function automatic int cnt_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/gsim_feeder_if.sv
// -----------------------------------------------------------------------------
// gsim_feeder_if
// Bundles the feeder's data-path signals:
//   load stream   : in_valid / in_ready / in_data
//   solver result : res_valid / res_data
//   shift register: sh_ctrl / sh_en / sh_in / sh_in2
// master modport : the environment (load source, solver, shift register)
// slave modport  : the feeder itself
// -----------------------------------------------------------------------------
interface gsim_feeder_if #(
   parameter int BIT_WIDTH = 32
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [BIT_WIDTH-1:0] in_data;
   logic                 res_valid;
   logic [BIT_WIDTH-1:0] res_data;
   logic [2:0]           sh_ctrl;
   logic                 sh_en;
   logic [BIT_WIDTH-1:0] sh_in;
   logic [BIT_WIDTH-1:0] sh_in2;

   modport master (
      output in_valid, in_data, res_valid, res_data,
      input  in_ready, sh_ctrl, sh_en, sh_in, sh_in2
   );

   modport slave (
      input  in_valid, in_data, res_valid, res_data,
      output in_ready, sh_ctrl, sh_en, sh_in, sh_in2
   );
endinterface

// File: rtl/gsim_feeder.sv
// -----------------------------------------------------------------------------
// gsim_feeder
// Feeds a DEPTH-element shift register for an iterative solver. After a start
// request it loads DEPTH initial words from the load stream, then forwards
// solver results into the shift register for iter_num full sweeps, and
// finally pulses done. Every insert appears on the shift-register port one
// cycle after the word is accepted.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle solve request (ignored while busy)
//   iter_num in   sweep count, sampled when start is accepted
//   bus      slave modport of gsim_feeder_if (load, result, shift-register)
//   busy     out  solve in progress (LOAD, RUN, FINISH)
//   done     out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module gsim_feeder
   import gsim_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int DEPTH     = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [7:0]     iter_num,
   gsim_feeder_if.slave   bus,
   output logic           busy,
   output logic           done
);

   localparam int            CW        = cnt_width(DEPTH);
   localparam logic [CW-1:0] LAST_ELEM = CW'(DEPTH - 1);

   state_e               r_state;
   logic [7:0]           r_iter_num;
   logic [CW-1:0]        r_elem_cnt;
   logic [7:0]           r_iter_cnt;
   sh_cmd_e              r_sh_ctrl;
   logic                 r_sh_en;
   logic [BIT_WIDTH-1:0] r_sh_in;
   logic                 r_in_ready;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_load_acc;
   logic                 w_run_ins;
   logic                 w_elem_wrap;
   logic [7:0]           w_iter_next;

   // Handshake qualifiers and counter helpers.
   assign w_load_acc  = (r_state == LOAD) && bus.in_valid && r_in_ready;
   assign w_run_ins   = (r_state == RUN) && bus.res_valid;
   assign w_elem_wrap = (r_elem_cnt == LAST_ELEM);
   assign w_iter_next = r_iter_cnt + 8'd1;

   // Feeder FSM with counters and the registered output stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_iter_num <= 8'd0;
         r_elem_cnt <= '0;
         r_iter_cnt <= 8'd0;
         r_sh_ctrl  <= SH0;
         r_sh_en    <= 1'b0;
         r_sh_in    <= {BIT_WIDTH{1'b0}};
         r_in_ready <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         // Hold command unless an insert is issued below; sh_in keeps its value.
         r_sh_ctrl <= SH0;
         r_sh_en   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_iter_num <= iter_num;
                  r_elem_cnt <= '0;
                  r_iter_cnt <= 8'd0;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               if (w_load_acc) begin
                  r_sh_ctrl <= SH1;
                  r_sh_en   <= 1'b1;
                  r_sh_in   <= bus.in_data;
                  if (w_elem_wrap) begin
                     r_elem_cnt <= '0;
                     r_in_ready <= 1'b0;
                     // A zero sweep count means the load alone is the whole solve.
                     r_state    <= (r_iter_num == 8'd0) ? FINISH : RUN;
                  end else begin
                     r_elem_cnt <= r_elem_cnt + CW'(1);
                  end
               end
            end
            RUN: begin
               if (w_run_ins) begin
                  r_sh_ctrl <= SH1;
                  r_sh_en   <= 1'b1;
                  r_sh_in   <= bus.res_data;
                  if (w_elem_wrap) begin
                     r_elem_cnt <= '0;
                     r_iter_cnt <= w_iter_next;
                     if (w_iter_next == r_iter_num) begin
                        r_state <= FINISH;
                     end
                  end else begin
                     r_elem_cnt <= r_elem_cnt + CW'(1);
                  end
               end
            end
            FINISH: begin
               // First FINISH cycle lets the last insert show; the second
               // carries done, after which busy and done fall together.
               if (!r_done) begin
                  r_done <= 1'b1;
               end else begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.sh_ctrl  = r_sh_ctrl;
   assign bus.sh_en    = r_sh_en;
   assign bus.sh_in    = r_sh_in;
   assign bus.sh_in2   = {BIT_WIDTH{1'b0}};
   assign bus.in_ready = r_in_ready;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_gsim_feeder.sv
// -----------------------------------------------------------------------------
// tb_gsim_feeder
// Self-checking bench for gsim_feeder: a phase-level model of the solve
// (load DEPTH words, then DEPTH*iter_num results, then a done pulse) is
// compared against every DUT output on every falling edge, with directed
// scenarios plus randomized solves and literal spot checks.
// -----------------------------------------------------------------------------
module tb_gsim_feeder;
   localparam int BW    = 32;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] iter_num = 8'd0;
   logic       busy, done;

   gsim_feeder_if #(.BIT_WIDTH(BW)) bus ();

   gsim_feeder #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .iter_num (iter_num),
      .bus      (bus),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int ins_seen = 0;
   int done_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 loading, 2 running, 3 finishing, 4 done cycle
   int          m_phase = 0;
   int          m_loaded, m_run, m_iters;
   logic        m_ins = 1'b0;
   logic [31:0] m_last = 32'h0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_ins = 1'b0; m_last = 32'h0;
         m_loaded = 0; m_run = 0; m_iters = 0;
      end else begin
         m_ins = 1'b0;
         case (m_phase)
            0: if (start) begin m_iters = int'(iter_num); m_loaded = 0; m_phase = 1; end
            1: if (bus.in_valid) begin
                  m_ins = 1'b1; m_last = bus.in_data; m_loaded++;
                  if (m_loaded == DEPTH) begin
                     m_run = 0;
                     m_phase = (m_iters == 0) ? 3 : 2;
                  end
               end
            2: if (bus.res_valid) begin
                  m_ins = 1'b1; m_last = bus.res_data; m_run++;
                  if (m_run == DEPTH * m_iters) m_phase = 3;
               end
            3: m_phase = 4;
            default: m_phase = 0;
         endcase
      end
   end

   // Compare process: all outputs against the model on every falling edge.
   always @(negedge clk) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_phase == 1));
      chk("busy",     32'(busy),         32'(m_phase != 0));
      chk("done",     32'(done),         32'(m_phase == 4));
      chk("sh_en",    32'(bus.sh_en),    32'(m_ins));
      chk("sh_ctrl",  32'(bus.sh_ctrl),  m_ins ? 32'd1 : 32'd0);
      chk("sh_in",    bus.sh_in,         m_last);
      chk("sh_in2",   bus.sh_in2,        32'h0);
      if (bus.sh_en === 1'b1) ins_seen++;
      if (done === 1'b1) done_seen++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_start(input logic [7:0] it);
      @(negedge clk); #1; start = 1'b1; iter_num = it;
      @(negedge clk); #1; start = 1'b0; iter_num = $urandom_range(0, 255);
   endtask

   // Load n words; mode 0 back-to-back counting data from 1, 1 alternate, 2 random.
   task automatic load_words(input int n, input int mode);
      int sent = 0; int step = 0; int budget = 2000;
      logic v;
      while (sent < n && budget > 0) begin
         @(negedge clk); #1;
         case (mode)
            0: v = 1'b1;
            1: v = (step % 2 == 0);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         bus.in_valid = v;
         bus.in_data  = (mode == 2) ? $urandom : 32'(sent + 1);
         if (v && bus.in_ready) sent++;
         step++; budget--;
      end
      if (budget == 0) chk("load_budget", 32'(sent), 32'(n));
      @(negedge clk); #1; bus.in_valid = 1'b0;
   endtask

   // Send n results; random gaps if rnd, junk start/in_valid if junk.
   task automatic run_res(input int n, input bit rnd, input bit junk);
      int sent = 0;
      logic v;
      while (sent < n) begin
         @(negedge clk); #1;
         v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.res_valid = v;
         bus.res_data  = rnd ? $urandom : 32'(32'h100 + sent);
         if (junk) begin
            start = $urandom_range(0, 1);
            bus.in_valid = $urandom_range(0, 1);
            bus.in_data = $urandom;
         end
         if (v) sent++;
      end
      @(negedge clk); #1;
      bus.res_valid = 1'b0; start = 1'b0; bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int d0 = done_seen;
      int budget = 10;
      while (done_seen == d0 && budget > 0) begin
         @(negedge clk); #1; budget--;
      end
      chk(name, 32'(done_seen - d0), 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   // Hard wall-clock guard against a hung run.
   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, d0, it;
      bus.in_valid = 1'b0; bus.in_data = 32'h0;
      bus.res_valid = 1'b0; bus.res_data = 32'h0;
      idle(3);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Back-to-back load 1..16, then 32 results, junk start/in_valid in RUN.
      c0 = ins_seen;
      do_start(8'd2);
      load_words(DEPTH, 0);
      chk("load_ins", 32'(ins_seen - c0), 32'd16);
      chk("load_last", bus.sh_in, 32'h10);
      c0 = ins_seen;
      run_res(2 * DEPTH, 1'b0, 1'b1);
      chk("run_last", bus.sh_in, 32'h11f);
      wait_done("done_iter2");
      chk("run_ins", 32'(ins_seen - c0), 32'd32);
      idle(3);
      chk("busy_after", 32'(busy), 32'd0);

      // Alternating in_valid load, iter 1, random results.
      c0 = ins_seen;
      do_start(8'd1);
      load_words(DEPTH, 1);
      chk("alt_ins", 32'(ins_seen - c0), 32'd16);
      run_res(DEPTH, 1'b1, 1'b0);
      wait_done("done_alt");

      // iter_num = 0 with res_valid held high throughout.
      @(negedge clk); #1; bus.res_valid = 1'b1; bus.res_data = 32'hdead;
      c0 = ins_seen;
      do_start(8'd0);
      load_words(DEPTH, 0);
      wait_done("done_iter0");
      idle(4);
      chk("iter0_ins", 32'(ins_seen - c0), 32'd16);
      bus.res_valid = 1'b0;
      idle(2);

      // Reset in the middle of RUN at elem_cnt 7.
      d0 = done_seen;
      do_start(8'd1);
      load_words(DEPTH, 0);
      run_res(7, 1'b0, 1'b0);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0; #1;
      chk("rst_sh_in", bus.sh_in, 32'h0);
      chk("rst_sh_en", 32'(bus.sh_en), 32'd0);
      chk("rst_sh_ctrl", 32'(bus.sh_ctrl), 32'd0);
      chk("rst_busy2", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready2", 32'(bus.in_ready), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(6);
      chk("rst_no_done", 32'(done_seen - d0), 32'd0);
      c0 = ins_seen;
      do_start(8'd1);
      load_words(DEPTH, 0);
      chk("reload_ins", 32'(ins_seen - c0), 32'd16);
      run_res(DEPTH, 1'b1, 1'b0);
      wait_done("done_reload");

      // Randomized solves.
      for (int s = 0; s < 8; s++) begin
         it = $urandom_range(0, 3);
         do_start(8'(it));
         load_words(DEPTH, 2);
         if (it > 0) run_res(DEPTH * it, 1'b1, (s % 2) == 1);
         wait_done("done_rand");
         idle($urandom_range(1, 4));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
